// File: rtl/packet_rx_parser_pkg.sv
// Shared types and constants for the received-packet parser.
// Frame layout, packet type codes and parser states.
package packet_rx_parser_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;
    localparam int FRAME_LEN  = 9;

    typedef enum logic [2:0] {
        PT_HELLO  = 3'd1,
        PT_CH_ADV = 3'd2,
        PT_JOIN   = 3'd3,
        PT_DATA   = 3'd4
    } pktType_e;

    localparam logic [3:0] IDX_HDR    = 4'd0;
    localparam logic [3:0] IDX_SRC_HI = 4'd1;
    localparam logic [3:0] IDX_SRC_LO = 4'd2;
    localparam logic [3:0] IDX_CLU_HI = 4'd3;
    localparam logic [3:0] IDX_CLU_LO = 4'd4;
    localparam logic [3:0] IDX_ENG_HI = 4'd5;
    localparam logic [3:0] IDX_ENG_LO = 4'd6;
    localparam logic [3:0] IDX_QV_HI  = 4'd7;
    localparam logic [3:0] IDX_QV_LO  = 4'd8;
    localparam logic [3:0] IDX_LAST   = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_WAIT_SOF  = 2'd0,
        S_BODY      = 2'd1,
        S_CHECK     = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/packet_rx_parser_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter
    import packet_rx_parser_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign count = cnt;

endmodule

// File: rtl/packet_rx_parser.sv
// Deframes the received byte stream into Q-table update fields,
// filters unwanted packets and hands accepted ones to the updater.
module packet_rx_parser
    import packet_rx_parser_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] NODE_ID     = 16'h0001,
    parameter logic [7:0]            ACCEPT_MASK = 8'b0001_1110
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [2:0]            fPacketType,
    output logic [WORD_WIDTH-1:0] fSourceID,
    output logic [WORD_WIDTH-1:0] fClusterID,
    output logic [WORD_WIDTH-1:0] fEnergyLeft,
    output logic [WORD_WIDTH-1:0] fQValue,
    output logic                  upd_en,
    input  logic                  upd_done,
    output logic [WORD_WIDTH-1:0] rx_count,
    output logic [WORD_WIDTH-1:0] drop_count
);

    localparam int HI = WORD_WIDTH - 1;
    localparam int LO = BYTE_WIDTH;

    state_e state;
    state_e stateNxt;

    logic       take;
    logic       isAccept;
    logic       incRx;
    logic       incDrop;
    logic       ldHdr;
    logic       ldBody;
    logic       ldOut;
    logic       updNxt;
    logic [3:0] idx;

    logic [2:0]            shType;
    logic [WORD_WIDTH-1:0] shSrc;
    logic [WORD_WIDTH-1:0] shClu;
    logic [WORD_WIDTH-1:0] shEng;
    logic [WORD_WIDTH-1:0] shQv;

    // Gated by nrst so the port reads 0 throughout the reset cycle.
    assign in_ready = nrst && ((state == S_WAIT_SOF) || (state == S_BODY));
    assign take     = in_valid && in_ready;
    assign isAccept = ACCEPT_MASK[shType] && (shSrc != NODE_ID);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_WAIT_SOF;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        incRx    = 1'b0;
        incDrop  = 1'b0;
        ldHdr    = 1'b0;
        ldBody   = 1'b0;
        ldOut    = 1'b0;
        updNxt   = 1'b0;
        case (state)
            S_WAIT_SOF: begin
                if (take && in_sof) begin
                    ldHdr    = 1'b1;
                    stateNxt = S_BODY;
                end
            end
            S_BODY: begin
                if (take) begin
                    if (in_sof) begin
                        // Restart on the new header; the partial frame is dropped.
                        incDrop = 1'b1;
                        ldHdr   = 1'b1;
                    end else begin
                        ldBody = 1'b1;
                        if (idx == IDX_LAST) begin
                            stateNxt = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (isAccept) begin
                    ldOut    = 1'b1;
                    incRx    = 1'b1;
                    updNxt   = 1'b1;
                    stateNxt = S_WAIT_DONE;
                end else begin
                    incDrop  = 1'b1;
                    stateNxt = S_WAIT_SOF;
                end
            end
            S_WAIT_DONE: begin
                if (upd_done) begin
                    stateNxt = S_WAIT_SOF;
                end
            end
            default: begin
                stateNxt = S_WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            idx         <= IDX_HDR;
            shType      <= '0;
            shSrc       <= '0;
            shClu       <= '0;
            shEng       <= '0;
            shQv        <= '0;
            fPacketType <= '0;
            fSourceID   <= '0;
            fClusterID  <= '0;
            fEnergyLeft <= '0;
            fQValue     <= '0;
            upd_en      <= 1'b0;
        end else begin
            upd_en <= updNxt;
            if (ldHdr) begin
                shType <= in_data[BYTE_WIDTH-1 -: 3];
                idx    <= IDX_SRC_HI;
            end
            if (ldBody) begin
                idx <= idx + 4'd1;
                case (idx)
                    IDX_SRC_HI: shSrc[HI:LO]  <= in_data;
                    IDX_SRC_LO: shSrc[LO-1:0] <= in_data;
                    IDX_CLU_HI: shClu[HI:LO]  <= in_data;
                    IDX_CLU_LO: shClu[LO-1:0] <= in_data;
                    IDX_ENG_HI: shEng[HI:LO]  <= in_data;
                    IDX_ENG_LO: shEng[LO-1:0] <= in_data;
                    IDX_QV_HI:  shQv[HI:LO]   <= in_data;
                    IDX_QV_LO:  shQv[LO-1:0]  <= in_data;
                    default: ;
                endcase
            end
            // Outputs change only here, so they stay stable for the updater.
            if (ldOut) begin
                fPacketType <= shType;
                fSourceID   <= shSrc;
                fClusterID  <= shClu;
                fEnergyLeft <= shEng;
                fQValue     <= shQv;
            end
        end
    end

    sat_counter #(
        .WIDTH (WORD_WIDTH)
    ) uRxCnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (incRx),
        .count (rx_count)
    );

    sat_counter #(
        .WIDTH (WORD_WIDTH)
    ) uDropCnt (
        .clk   (clk),
        .nrst  (nrst),
        .inc   (incDrop),
        .count (drop_count)
    );

endmodule

// File: tb/tb_packet_rx_parser.sv
// Directed bench for packet_rx_parser: frame table plus
// abort, gap, saturation and mid-packet reset sequences.
module tb_packet_rx_parser;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [2:0]  fPacketType;
    logic [15:0] fSourceID;
    logic [15:0] fClusterID;
    logic [15:0] fEnergyLeft;
    logic [15:0] fQValue;
    logic        upd_en;
    logic        upd_done;
    logic [15:0] rx_count;
    logic [15:0] drop_count;

    int nCmp  = 0;
    int nFail = 0;
    int updCount = 0;
    int expUpd = 0;

    always #5 clk = ~clk;

    packet_rx_parser dut (
        .clk         (clk),
        .nrst        (nrst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .fPacketType (fPacketType),
        .fSourceID   (fSourceID),
        .fClusterID  (fClusterID),
        .fEnergyLeft (fEnergyLeft),
        .fQValue     (fQValue),
        .upd_en      (upd_en),
        .upd_done    (upd_done),
        .rx_count    (rx_count),
        .drop_count  (drop_count)
    );

    always @(negedge clk) begin
        if (upd_en) updCount++;
    end

    typedef struct {
        logic [7:0]  hdr;
        logic [15:0] src, clu, eng, qv;
        bit          acc;
        int          delay;
        logic [2:0]  eType;
        logic [15:0] eSrc, eClu, eEng, eQv;
        logic [15:0] eRx, eDrop;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkFields(input string tag, input logic [2:0] t,
                             input logic [15:0] s, input logic [15:0] c,
                             input logic [15:0] e, input logic [15:0] q);
        chk({tag, "_type"}, 32'(fPacketType), 32'(t));
        chk({tag, "_src"}, 32'(fSourceID), 32'(s));
        chk({tag, "_clu"}, 32'(fClusterID), 32'(c));
        chk({tag, "_eng"}, 32'(fEnergyLeft), 32'(e));
        chk({tag, "_qv"}, 32'(fQValue), 32'(q));
    endtask

    task automatic sendByte(input logic [7:0] d, input logic s, input int gap);
        int w;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        in_data  = d;
        in_sof   = s;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] hdr, input logic [15:0] s,
                             input logic [15:0] c, input logic [15:0] e,
                             input logic [15:0] q, input int maxGap);
        logic [7:0] b[9];
        b = '{hdr, s[15:8], s[7:0], c[15:8], c[7:0],
              e[15:8], e[7:0], q[15:8], q[7:0]};
        for (int i = 0; i < 9; i++) begin
            sendByte(b[i], i == 0, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    // Called one step after the edge that consumed the last byte.
    task automatic expectAccept(input string tag, input int delay,
                                input logic [2:0] t, input logic [15:0] s,
                                input logic [15:0] c, input logic [15:0] e,
                                input logic [15:0] q, input logic [15:0] eRx,
                                input logic [15:0] eDrop);
        chk({tag, "_rdy_chk"}, 32'(in_ready), 32'd0);
        chk({tag, "_upd_early"}, 32'(upd_en), 32'd0);
        tick();
        expUpd++;
        chk({tag, "_upd_en"}, 32'(upd_en), 32'd1);
        chkFields(tag, t, s, c, e, q);
        chk({tag, "_rx"}, 32'(rx_count), 32'(eRx));
        chk({tag, "_drop"}, 32'(drop_count), 32'(eDrop));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, "_upd_pulse"}, 32'(upd_en), 32'd0);
            chk({tag, "_rdy_wait"}, 32'(in_ready), 32'd0);
        end
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_upd_after"}, 32'(upd_en), 32'd0);
        chkFields({tag, "_hold"}, t, s, c, e, q);
    endtask

    task automatic expectReject(input string tag, input logic [2:0] t,
                                input logic [15:0] s, input logic [15:0] c,
                                input logic [15:0] e, input logic [15:0] q,
                                input logic [15:0] eRx, input logic [15:0] eDrop);
        chk({tag, "_rdy_chk"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        chk({tag, "_no_upd"}, 32'(upd_en), 32'd0);
        chk({tag, "_rx"}, 32'(rx_count), 32'(eRx));
        chk({tag, "_drop"}, 32'(drop_count), 32'(eDrop));
        chkFields(tag, t, s, c, e, q);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_upd"}, 32'(upd_en), 32'd0);
        chk({tag, "_rx"}, 32'(rx_count), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chkFields(tag, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        vecs[0] = '{8'h20, 16'h0005, 16'h0002, 16'h03E8, 16'h0064, 1, 3,
                    3'd1, 16'h0005, 16'h0002, 16'h03E8, 16'h0064, 16'd1, 16'd0};
        vecs[1] = '{8'h00, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 0, 0,
                    3'd1, 16'h0005, 16'h0002, 16'h03E8, 16'h0064, 16'd1, 16'd1};
        vecs[2] = '{8'h20, 16'h0001, 16'h0011, 16'h0022, 16'h0033, 0, 0,
                    3'd1, 16'h0005, 16'h0002, 16'h03E8, 16'h0064, 16'd1, 16'd2};
        vecs[3] = '{8'h40, 16'h1234, 16'h0056, 16'hABCD, 16'h7FFF, 1, 0,
                    3'd2, 16'h1234, 16'h0056, 16'hABCD, 16'h7FFF, 16'd2, 16'd2};
        vecs[4] = '{8'h80, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1, 1,
                    3'd4, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'd3, 16'd2};
        vecs[5] = '{8'hA0, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 0, 0,
                    3'd4, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'd3, 16'd3};
        vecs[6] = '{8'h7F, 16'hBEEF, 16'h0001, 16'h0000, 16'hFFFF, 1, 2,
                    3'd3, 16'hBEEF, 16'h0001, 16'h0000, 16'hFFFF, 16'd4, 16'd3};
        vecs[7] = '{8'hE0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0,
                    3'd3, 16'hBEEF, 16'h0001, 16'h0000, 16'hFFFF, 16'd4, 16'd4};

        nrst     = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        upd_done = 1'b0;
        tick();
        tick();
        chkAllZero("reset");
        nrst = 1'b1;
        tick();
        chk("rdy_post_reset", 32'(in_ready), 32'd1);

        // upd_done outside S_WAIT_DONE must be ignored
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;

        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            sendFrame(vecs[i].hdr, vecs[i].src, vecs[i].clu,
                      vecs[i].eng, vecs[i].qv, 0);
            if (vecs[i].acc) begin
                expectAccept(tag, vecs[i].delay, vecs[i].eType, vecs[i].eSrc,
                             vecs[i].eClu, vecs[i].eEng, vecs[i].eQv,
                             vecs[i].eRx, vecs[i].eDrop);
            end else begin
                expectReject(tag, vecs[i].eType, vecs[i].eSrc, vecs[i].eClu,
                             vecs[i].eEng, vecs[i].eQv, vecs[i].eRx,
                             vecs[i].eDrop);
            end
            chk({tag, "_updcnt"}, 32'(updCount), 32'(expUpd));
        end

        // Abort after 4 body bytes, then a good type-2 frame
        sendByte(8'h20, 1'b1, 0);
        sendByte(8'h00, 1'b0, 0);
        sendByte(8'h05, 1'b0, 0);
        sendByte(8'h00, 1'b0, 0);
        sendByte(8'h02, 1'b0, 0);
        sendFrame(8'h40, 16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD, 0);
        expectAccept("abort", 1, 3'd2, 16'h0AAA, 16'h0BBB, 16'h0CCC,
                     16'h0DDD, 16'd5, 16'd5);
        chk("abort_updcnt", 32'(updCount), 32'(expUpd));

        // Stray non-sof bytes, then a frame with valid gaps
        sendByte(8'h20, 1'b0, 0);
        sendByte(8'h55, 1'b0, 1);
        sendByte(8'hFF, 1'b0, 0);
        chk("stray_drop", 32'(drop_count), 32'd5);
        sendFrame(8'h60, 16'h0042, 16'h0003, 16'h0100, 16'h0200, 3);
        expectAccept("gaps", 2, 3'd3, 16'h0042, 16'h0003, 16'h0100,
                     16'h0200, 16'd6, 16'd5);

        // Saturation: preload the drop counter near the top
        force dut.uDropCnt.cnt = 16'hFFFD;
        tick();
        release dut.uDropCnt.cnt;
        tick();
        chk("sat_preload", 32'(drop_count), 32'hFFFD);
        sendFrame(8'h00, 16'h0009, 16'h0, 16'h0, 16'h0, 0);
        expectReject("sat1", 3'd3, 16'h0042, 16'h0003, 16'h0100, 16'h0200,
                     16'd6, 16'hFFFE);
        sendFrame(8'h00, 16'h0009, 16'h0, 16'h0, 16'h0, 0);
        expectReject("sat2", 3'd3, 16'h0042, 16'h0003, 16'h0100, 16'h0200,
                     16'd6, 16'hFFFF);
        sendFrame(8'h00, 16'h0009, 16'h0, 16'h0, 16'h0, 0);
        expectReject("sat3", 3'd3, 16'h0042, 16'h0003, 16'h0100, 16'h0200,
                     16'd6, 16'hFFFF);

        // Reset inside S_BODY
        sendByte(8'h20, 1'b1, 0);
        sendByte(8'h12, 1'b0, 0);
        sendByte(8'h34, 1'b0, 0);
        nrst = 1'b0;
        tick();
        chkAllZero("rst_body");
        nrst = 1'b1;
        tick();
        chk("rst_body_rdy", 32'(in_ready), 32'd1);
        sendFrame(8'h20, 16'h0005, 16'h0002, 16'h03E8, 16'h0064, 0);
        expectAccept("post_rst1", 1, 3'd1, 16'h0005, 16'h0002, 16'h03E8,
                     16'h0064, 16'd1, 16'd0);

        // Reset inside S_WAIT_DONE
        sendFrame(8'h80, 16'h0099, 16'h0098, 16'h0097, 16'h0096, 0);
        tick();
        expUpd++;
        chk("rst_wd_upd", 32'(upd_en), 32'd1);
        nrst = 1'b0;
        tick();
        chkAllZero("rst_wait");
        nrst = 1'b1;
        tick();
        sendFrame(8'h40, 16'h0777, 16'h0888, 16'h0999, 16'h0AAA, 2);
        expectAccept("post_rst2", 0, 3'd2, 16'h0777, 16'h0888, 16'h0999,
                     16'h0AAA, 16'd1, 16'd0);

        tick();
        chk("final_updcnt", 32'(updCount), 32'(expUpd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/packet_rx_parser.md
Name: packet_rx_parser

Overview:
- Upstream stage of the Q-table update block.
- Deframes the 8-bit received-packet byte stream into the 16-bit fields fSourceID, fClusterID, fEnergyLeft, fQValue and fPacketType.
- Filters out unwanted packets, then hands each accepted packet to the Q-table updater with a one-cycle enable pulse.
- Stalls the byte stream until the updater reports done.

Parameters:
- WORD_WIDTH, 16, width of every extracted field and of the counters.
- BYTE_WIDTH, 8, width of the input stream.
- NODE_ID, 16'h0001, own node ID; packets with this source ID are self-echoes and are dropped.
- ACCEPT_MASK, 8'b0001_1110, bit t set means packet type t is forwarded (default forwards types 1-4).

Ports:
- clk  input  1  clock
- nrst  input  1  reset, synchronous, active-low
- in_data  input  BYTE_WIDTH  received byte
- in_valid  input  1  in_data valid this cycle
- in_sof  input  1  in_data is the first (header) byte of a packet; qualified by in_valid
- in_ready  output  1  parser accepts a byte this cycle
- fPacketType  output  3  extracted packet type
- fSourceID, fClusterID, fEnergyLeft, fQValue  output  WORD_WIDTH each  extracted fields
- upd_en  output  1  one-cycle start pulse to the Q-table updater
- upd_done  input  1  updater finished
- rx_count  output  WORD_WIDTH  accepted-packet count, saturating
- drop_count  output  WORD_WIDTH  dropped/aborted-packet count, saturating

Behaviour:
- Frame format: 9 bytes; a byte is consumed on in_valid && in_ready.
  - Byte 0: header {type[2:0], 5'b0}; the reserved bits are ignored.
  - Bytes 1-8, big-endian: SourceID hi,lo; ClusterID hi,lo; Energy hi,lo; QValue hi,lo.
- Reset: state S_WAIT_SOF; all field outputs, upd_en, rx_count and drop_count are 0; in_ready is 0 during the reset cycle and 1 from the first cycle after reset.
- States:
  - S_WAIT_SOF:
    - in_ready=1.
    - Byte with in_sof=1: latch type into a shadow register, clear the byte index to 1, go to S_BODY.
    - Byte with in_sof=0: discarded silently, not counted.
  - S_BODY:
    - in_ready=1; each byte is shifted into the shadow field registers at index 1..8.
    - Index 8 accepted: go to S_CHECK.
    - Byte with in_sof=1 at any index: abort, drop_count+1, treat that byte as the new header (index 1, stay in S_BODY).
  - S_CHECK:
    - One cycle, in_ready=0.
    - Accept if ACCEPT_MASK[type]==1 and shadow SourceID!=NODE_ID.
    - Accept: copy shadow registers to the f* outputs, rx_count+1, go to S_WAIT_DONE.
    - Reject: drop_count+1, f* outputs unchanged, go to S_WAIT_SOF.
  - S_WAIT_DONE:
    - in_ready=0.
    - upd_en=1 in the first cycle of this state only (registered, exactly one cycle).
    - upd_done is sampled every cycle of this state, including the upd_en cycle; upd_done=1 -> S_WAIT_SOF.
    - upd_done outside S_WAIT_DONE is ignored.
- Latency: last byte accepted at edge E0, S_CHECK during the following cycle, upd_en high the cycle after that (2 cycles from last byte to upd_en).
- f* outputs hold stable from upd_en until the next accepted packet; the updater may read them throughout its operation.
- Counters saturate at 16'hFFFF, with no wrap.
- Gaps: in_valid=0 in the middle of a packet simply stalls, with no timeout.
- Reset mid-packet or mid-wait: full reset to the reset values; the partial packet is lost and not counted.
- Default case of the state register returns to S_WAIT_SOF.

Decomposition:
- Shared package holds:
  - WORD_WIDTH and BYTE_WIDTH.
  - Packet type codes: 1=HELLO, 2=CH_ADV, 3=JOIN, 4=DATA.
  - Frame length constant 9.
  - Byte-index constants for each field.
  - State encodings.
- One natural sub-module: sat_counter (WORD_WIDTH, inc input, saturating), instantiated twice for rx_count and drop_count.
- The frame shifter stays inline.

Test Plan:
- Send header 8'h20 (type 1), then 00 05 00 02 03 E8 00 64, with upd_done returned 3 cycles after upd_en -> fSourceID=5, fClusterID=2, fEnergyLeft=1000, fQValue=100, upd_en high exactly 1 cycle 2 cycles after the last byte, rx_count=1, in_ready low until the cycle after upd_done.
- Type 0 header 8'h00 with a valid body -> no upd_en, drop_count=1, f* outputs unchanged, in_ready=1 the cycle after S_CHECK.
- Type 1 with SourceID 16'h0001 (=NODE_ID) -> dropped, drop_count+1, no upd_en.
- New sof after 4 body bytes, then a full good type-2 frame -> drop_count+1, a single upd_en with the second frame's fields.
- Random in_valid gaps inside a frame, plus stray non-sof bytes before it -> fields correct, stray bytes not counted; then 65536 rejected frames (short-run force) -> drop_count stays at 16'hFFFF.
- nrst=0 asserted in S_BODY, and separately in S_WAIT_DONE -> all outputs 0 the next cycle; a following good frame parses normally.
